// File: rtl/fir_output_requantizer.sv
// FIR output requantizer: round, arithmetic shift and saturate the accumulator
// result, then buffer it in a small first-word-fall-through FIFO.
module fir_output_requantizer #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned OUT_WIDTH  = 16,
    parameter int unsigned SHIFT      = 8,
    parameter int unsigned ROUND      = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_en,
    input  logic [DATA_WIDTH-1:0]              iv_din,
    input  logic                               i_din_valid,
    output logic                               o_ready,
    output logic [OUT_WIDTH-1:0]               ov_dout,
    output logic                               o_dout_valid,
    input  logic                               i_ready,
    output logic                               o_sat,
    input  logic                               i_sat_clr,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    ov_count
);

    localparam int unsigned SUM_W  = DATA_WIDTH + 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CR_W   = CNT_W + 1;
    localparam int unsigned HI_W   = SUM_W - (OUT_WIDTH - 1);
    localparam int unsigned RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [SUM_W-1:0] RND =
        (ROUND != 0 && SHIFT > 0) ? (SUM_W'(1) << RND_SH) : '0;

    logic                     s1_valid;
    logic signed [SUM_W-1:0]  s1_sum;
    logic                     s2_valid;
    logic                     s2_sat;
    logic [OUT_WIDTH-1:0]     s2_data;
    logic [OUT_WIDTH-1:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;

    logic [CR_W-1:0]          in_use_c;
    logic                     accept_c;
    logic                     wr_c;
    logic                     rd_c;
    logic signed [SUM_W-1:0]  q_c;
    logic [HI_W-1:0]          q_hi_c;
    logic                     ovf_pos_c;
    logic                     ovf_neg_c;
    logic [OUT_WIDTH-1:0]     sat_data_c;

    // Credit check: buffered plus in-flight words must leave room for one more.
    always_comb begin
        in_use_c     = CR_W'(ov_count) + CR_W'(s1_valid) + CR_W'(s2_valid);
        o_ready      = i_en && !i_rst && (in_use_c < CR_W'(FIFO_DEPTH));
        accept_c     = i_din_valid && o_ready;
        o_dout_valid = (ov_count != '0);
        wr_c         = i_en && s2_valid;
        rd_c         = i_en && o_dout_valid && i_ready;
        ov_dout      = o_dout_valid ? mem[rd_ptr] : '0;
    end

    // Saturation: every bit above the output sign bit must match the sign.
    always_comb begin
        q_c       = s1_sum >>> SHIFT;
        q_hi_c    = q_c[SUM_W-1:OUT_WIDTH-1];
        ovf_pos_c = !q_hi_c[HI_W-1] && (q_hi_c != '0);
        ovf_neg_c = q_hi_c[HI_W-1] && (q_hi_c != '1);
        sat_data_c = q_c[OUT_WIDTH-1:0];
        if (ovf_pos_c) begin
            sat_data_c = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else if (ovf_neg_c) begin
            sat_data_c = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end
    end

    // Datapath stages; qualified by the valid bits, so no reset needed.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            s1_sum  <= {iv_din[DATA_WIDTH-1], iv_din} + RND;
            s2_data <= sat_data_c;
            s2_sat  <= ovf_pos_c || ovf_neg_c;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_c) begin
            mem[wr_ptr] <= s2_data;
        end
    end

    // Control: stage valids, FIFO pointers/occupancy and sticky saturation flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ov_count <= '0;
            o_sat    <= 1'b0;
        end else if (i_en) begin
            s1_valid <= accept_c;
            s2_valid <= s1_valid;
            if (wr_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_c, rd_c})
                2'b10:   ov_count <= ov_count + CNT_W'(1);
                2'b01:   ov_count <= ov_count - CNT_W'(1);
                default: ov_count <= ov_count;
            endcase
            if (wr_c && s2_sat) begin
                o_sat <= 1'b1;
            end else if (i_sat_clr) begin
                o_sat <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_output_requantizer.sv
// Directed bench for fir_output_requantizer: vector table for the arithmetic,
// hand-written sequences for handshake, enable, and reset corner cases.
module tb_fir_output_requantizer;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_en;
    logic [23:0] iv_din;
    logic        i_din_valid;
    logic        o_ready;
    logic [15:0] ov_dout;
    logic        o_dout_valid;
    logic        i_ready;
    logic        o_sat;
    logic        i_sat_clr;
    logic [2:0]  ov_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 i_clk = ~i_clk;

    fir_output_requantizer dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_en         (i_en),
        .iv_din       (iv_din),
        .i_din_valid  (i_din_valid),
        .o_ready      (o_ready),
        .ov_dout      (ov_dout),
        .o_dout_valid (o_dout_valid),
        .i_ready      (i_ready),
        .o_sat        (o_sat),
        .i_sat_clr    (i_sat_clr),
        .ov_count     (ov_count)
    );

    typedef struct {
        logic [23:0] din;
        logic [15:0] dout;
        logic        sat;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Offer one word and return just after the edge that accepted it.
    task automatic push(input logic [23:0] d, input string name);
        bit done = 1'b0;
        iv_din      = d;
        i_din_valid = 1'b1;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (o_ready) begin
                tick();
                done = 1'b1;
                break;
            end
            tick();
            #1;
        end
        i_din_valid = 1'b0;
        check({name, " accepted"}, 32'(done), 32'd1);
    endtask

    task automatic wait_count(input int n, input string name);
        for (int i = 0; i < 20; i++) begin
            if (int'(ov_count) == n) break;
            tick();
        end
        check(name, 32'(ov_count), 32'(n));
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] outs [$];
        int          k;
        int          accepted;
        bit          acc;
        bit          pop;
        logic [15:0] d;

        vecs[0]  = '{24'h000180, 16'h0002, 1'b0};
        vecs[1]  = '{24'h00017F, 16'h0001, 1'b0};
        vecs[2]  = '{24'hFFFE80, 16'hFFFF, 1'b0};
        vecs[3]  = '{24'h000000, 16'h0000, 1'b0};
        vecs[4]  = '{24'hFFFF80, 16'h0000, 1'b0};
        vecs[5]  = '{24'hFFFF7F, 16'hFFFF, 1'b0};
        vecs[6]  = '{24'h7FFF7F, 16'h7FFF, 1'b0};
        vecs[7]  = '{24'h7FFF80, 16'h7FFF, 1'b1};
        vecs[8]  = '{24'h800000, 16'h8000, 1'b0};
        vecs[9]  = '{24'h7FFFFF, 16'h7FFF, 1'b1};
        vecs[10] = '{24'h80007F, 16'h8000, 1'b0};
        vecs[11] = '{24'hFF8000, 16'hFF80, 1'b0};

        i_rst = 1'b1; i_en = 1'b1; iv_din = '0; i_din_valid = 1'b0;
        i_ready = 1'b0; i_sat_clr = 1'b0;
        tick();
        tick();
        check("rst o_ready", 32'(o_ready), 32'd0);
        check("rst o_dout_valid", 32'(o_dout_valid), 32'd0);
        check("rst ov_dout", 32'(ov_dout), 32'd0);
        check("rst ov_count", 32'(ov_count), 32'd0);
        check("rst o_sat", 32'(o_sat), 32'd0);
        i_rst = 1'b0;
        #1;
        check("post-rst o_ready", 32'(o_ready), 32'd1);

        // Arithmetic table: latency, value and saturation flag per vector.
        i_ready = 1'b1;
        foreach (vecs[v]) begin
            push(vecs[v].din, $sformatf("vec%0d", v));
            check($sformatf("vec%0d valid@N", v), 32'(o_dout_valid), 32'd0);
            tick();
            check($sformatf("vec%0d valid@N+1", v), 32'(o_dout_valid), 32'd0);
            tick();
            check($sformatf("vec%0d valid@N+2", v), 32'(o_dout_valid), 32'd1);
            check($sformatf("vec%0d dout", v), 32'(ov_dout), 32'(vecs[v].dout));
            check($sformatf("vec%0d sat", v), 32'(o_sat), 32'(vecs[v].sat));
            tick();
            check($sformatf("vec%0d popped", v), 32'(ov_count), 32'd0);
            i_sat_clr = 1'b1;
            tick();
            i_sat_clr = 1'b0;
            check($sformatf("vec%0d sat clr", v), 32'(o_sat), 32'd0);
        end

        // Saturating write and clear on the same edge: set wins.
        push(24'h7FFFFF, "satclr");
        tick();
        i_sat_clr = 1'b1;
        tick();
        i_sat_clr = 1'b0;
        check("sat set wins", 32'(o_sat), 32'd1);
        check("sat set wins dout", 32'(ov_dout), 32'h7FFF);
        tick();
        i_sat_clr = 1'b1;
        tick();
        i_sat_clr = 1'b0;
        check("sat clear pulse", 32'(o_sat), 32'd0);

        // Backpressure: only FIFO_DEPTH words accepted while i_ready is low.
        do_reset();
        i_ready = 1'b0; k = 1; accepted = 0;
        for (int c = 0; c < 10; c++) begin
            iv_din = 24'(k << 8); i_din_valid = 1'b1;
            #1;
            acc = o_ready;
            tick();
            if (acc) begin k++; accepted++; end
        end
        #1;
        check("bp accepts", 32'(accepted), 32'd4);
        check("bp count full", 32'(ov_count), 32'd4);
        check("bp o_ready low", 32'(o_ready), 32'd0);
        i_ready = 1'b1;
        for (int c = 0; c < 30 && outs.size() < 6; c++) begin
            if (k <= 6) begin iv_din = 24'(k << 8); i_din_valid = 1'b1; end
            else i_din_valid = 1'b0;
            #1;
            acc = i_din_valid && o_ready;
            pop = o_dout_valid;
            d   = ov_dout;
            tick();
            if (acc) k++;
            if (pop) outs.push_back(d);
        end
        i_din_valid = 1'b0;
        check("bp all accepted", 32'(k), 32'd7);
        check("bp out count", 32'(outs.size()), 32'd6);
        for (int j = 0; j < outs.size(); j++)
            check($sformatf("bp out%0d", j), 32'(outs[j]), 32'(j + 1));
        tick();
        check("bp drained", 32'(ov_count), 32'd0);

        // One pop from a full FIFO frees exactly one credit.
        i_ready = 1'b0;
        for (int j = 10; j < 14; j++) push(24'(j << 8), $sformatf("full w%0d", j));
        wait_count(4, "full count");
        iv_din = 24'(14 << 8); i_din_valid = 1'b1;
        #1;
        check("full o_ready low", 32'(o_ready), 32'd0);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        #1;
        check("full after pop count", 32'(ov_count), 32'd3);
        check("full after pop o_ready", 32'(o_ready), 32'd1);
        tick();
        i_din_valid = 1'b0;
        #1;
        check("full credit used", 32'(o_ready), 32'd0);
        tick();
        tick();
        check("full refilled", 32'(ov_count), 32'd4);
        outs.delete();
        i_ready = 1'b1;
        for (int c = 0; c < 10 && outs.size() < 4; c++) begin
            #1;
            pop = o_dout_valid;
            d   = ov_dout;
            tick();
            if (pop) outs.push_back(d);
        end
        check("full out count", 32'(outs.size()), 32'd4);
        for (int j = 0; j < outs.size(); j++)
            check($sformatf("full out%0d", j), 32'(outs[j]), 32'(j + 11));

        // Enable freeze with two words in flight, then with a word at the head.
        do_reset();
        i_ready = 1'b1;
        push(24'h000500, "en w0");
        push(24'h000600, "en w1");
        i_en = 1'b0;
        iv_din = 24'h000700; i_din_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("freeze%0d o_ready", c), 32'(o_ready), 32'd0);
            check($sformatf("freeze%0d valid", c), 32'(o_dout_valid), 32'd0);
            check($sformatf("freeze%0d count", c), 32'(ov_count), 32'd0);
            tick();
        end
        i_din_valid = 1'b0;
        i_en = 1'b1;
        tick();
        check("en w0 valid", 32'(o_dout_valid), 32'd1);
        check("en w0 dout", 32'(ov_dout), 32'h0005);
        i_en = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            check($sformatf("hold%0d dout", c), 32'(ov_dout), 32'h0005);
            check($sformatf("hold%0d count", c), 32'(ov_count), 32'd1);
        end
        i_en = 1'b1;
        tick();
        check("en w1 dout", 32'(ov_dout), 32'h0006);
        check("en w1 count", 32'(ov_count), 32'd1);
        tick();
        check("en drained", 32'(ov_count), 32'd0);

        // Reset with buffered words and sticky saturation set.
        i_ready = 1'b0;
        push(24'h7FFFFF, "rst w0");
        push(24'h000100, "rst w1");
        push(24'h000200, "rst w2");
        wait_count(3, "rst fill count");
        check("rst fill sat", 32'(o_sat), 32'd1);
        i_rst = 1'b1;
        iv_din = 24'h000900; i_din_valid = 1'b1;
        #1;
        check("in-rst o_ready", 32'(o_ready), 32'd0);
        tick();
        check("mid-rst valid", 32'(o_dout_valid), 32'd0);
        check("mid-rst count", 32'(ov_count), 32'd0);
        check("mid-rst sat", 32'(o_sat), 32'd0);
        check("mid-rst dout", 32'(ov_dout), 32'd0);
        check("mid-rst o_ready", 32'(o_ready), 32'd0);
        i_rst = 1'b0;
        i_din_valid = 1'b0;
        push(24'h000300, "post-rst");
        check("post-rst valid@N", 32'(o_dout_valid), 32'd0);
        tick();
        check("post-rst valid@N+1", 32'(o_dout_valid), 32'd0);
        tick();
        check("post-rst valid@N+2", 32'(o_dout_valid), 32'd1);
        check("post-rst dout", 32'(ov_dout), 32'h0003);
        check("post-rst count", 32'(ov_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
